// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage:
//   INIT_32          - filler value driven on pc_out/instructions_out when empty
//   DEFAULT_RESET_PC - default fetch address after reset
//   CNT_W            - width of the fetch-buffer occupancy count (depth <= 4)
//   fetch_state_e    - FETCH_IDLE / FETCH_REQ / FETCH_DROP
//   fetch_entry_t    - one buffered {pc, instruction} pair
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam logic [31:0] INIT_32          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          CNT_W            = 3;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,  // no request outstanding
    FETCH_REQ  = 2'd1,  // request outstanding, data will be kept
    FETCH_DROP = 2'd2   // request outstanding, data will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Small FIFO of {pc, instruction} entries between the fetch FSM and IF/ID.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   i_push    - write i_data at the tail
//   i_pop     - drop the head entry
//   i_clear   - empty the FIFO (wins over push/pop)
//   i_data    - entry to write
//   o_count   - current occupancy
//   o_head    - head entry (meaningful only when o_count != 0)
// -----------------------------------------------------------------------------
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  fetch_entry_t     i_data,
  output logic [CNT_W-1:0] o_count,
  output fetch_entry_t     o_head
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // NOTE: the storage array has no reset; a slot is only read after it has
  // been written, as tracked by r_count.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage feeding the IF/ID register. Keeps the fetch PC,
// issues one outstanding req/ack request at a time to instruction memory,
// buffers returned {pc, instr} pairs in fetch_buf and presents the head.
// Redirects flush the buffer; a redirect that hits an in-flight request turns
// it into a drop (its data is discarded when the ack arrives).
//
// Parameters: RESET_PC (fetch address after reset), BUF_DEPTH (2 or 4).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   stall_C[0]          - block new fetch launches
//   stall_C[1]          - IF/ID holding: do not pop the head
//   redirect_en/_pc     - taken branch/jump and its target
//   imem_req/imem_addr  - registered memory request and word address
//   imem_ack/imem_rdata - request completion and instruction word
//   pc_out, instructions_out, valid_out - buffer head towards IF/ID
//
// Build option: define FETCH_BYPASS_EN to forward an ack straight to the
// outputs when the buffer is empty (one cycle less first-fetch latency).
// Without it the outputs come only from buffer registers.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  stall_C,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instructions_out,
  output logic        valid_out
);

  fetch_state_e     r_state,    w_state_nxt;
  logic [31:0]      r_fetch_pc, w_fetch_pc_nxt;
  logic             r_req,      w_req_nxt;
  logic [31:0]      r_addr,     w_addr_nxt;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_next_count;
  fetch_entry_t     w_buf_head;
  fetch_entry_t     w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_bypass;
  logic             w_buf_push;
  logic             w_buf_pop;
  logic             w_launch_ok;
  logic [31:0]      w_redirect_pc;
  logic             w_unused;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = ^{stall_C[3:2], redirect_pc[1:0]};

  // Data is kept only for a request that no redirect has overtaken.
  assign w_push = (r_state == FETCH_REQ) && imem_ack && !redirect_en;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_push && (w_count == '0);
  assign w_head   = w_bypass ? '{pc: r_addr, instr: imem_rdata} : w_buf_head;
`else
  assign w_bypass = 1'b0;
  assign w_head   = w_buf_head;
`endif

  assign valid_out        = (w_count != '0) || w_bypass;
  assign pc_out           = valid_out ? w_head.pc    : INIT_32;
  assign instructions_out = valid_out ? w_head.instr : INIT_32;

  assign w_pop        = valid_out && !stall_C[1];
  assign w_next_count = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  // A launch is only allowed when its data is guaranteed a free slot.
  assign w_launch_ok  = !stall_C[0] && (w_next_count < CNT_W'(BUF_DEPTH)) && !redirect_en;

  // A bypassed entry consumed in the same cycle never enters the buffer.
  assign w_buf_push = w_push && !(w_bypass && w_pop);
  assign w_buf_pop  = w_pop && !w_bypass;

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_buf_push),
    .i_pop   (w_buf_pop),
    .i_clear (redirect_en),
    .i_data  ('{pc: r_addr, instr: imem_rdata}),
    .o_count (w_count),
    .o_head  (w_buf_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;

    unique case (r_state)
      FETCH_IDLE: begin
        if (redirect_en) begin
          w_fetch_pc_nxt = w_redirect_pc;
        end else if (w_launch_ok) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
          w_state_nxt = FETCH_REQ;
        end
      end

      FETCH_REQ: begin
        if (imem_ack) begin
          if (redirect_en) begin
            // Buffer is being cleared, so space is guaranteed for the relaunch.
            w_fetch_pc_nxt = w_redirect_pc;
            if (!stall_C[0]) begin
              w_addr_nxt = w_redirect_pc;
            end else begin
              w_req_nxt   = 1'b0;
              w_state_nxt = FETCH_IDLE;
            end
          end else begin
            w_fetch_pc_nxt = next_pc(r_addr);
            if (w_launch_ok) begin
              w_addr_nxt = next_pc(r_addr);
            end else begin
              w_req_nxt   = 1'b0;
              w_state_nxt = FETCH_IDLE;
            end
          end
        end else if (redirect_en) begin
          // Request must complete on the bus; its data is thrown away later.
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = FETCH_DROP;
        end
      end

      FETCH_DROP: begin
        if (redirect_en) w_fetch_pc_nxt = w_redirect_pc;
        if (imem_ack) begin
          if (w_launch_ok) begin
            w_addr_nxt  = r_fetch_pc;
            w_state_nxt = FETCH_REQ;
          end else begin
            w_req_nxt   = 1'b0;
            w_state_nxt = FETCH_IDLE;
          end
        end
      end

      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = FETCH_IDLE;
      end
    endcase
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A memory model answers requests with a
// configurable latency and returns addr ^ 32'hA5A5_A5A5. A transaction-level
// reference tracks the fetch stream: the address every new request must use,
// the queue of kept {pc} entries the head must show, and which in-flight
// request a redirect has overtaken.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam int          TB_DEPTH    = 2;
  localparam logic [31:0] EMPTY_WORD  = 32'h0000_0000;
  localparam logic [31:0] SENTINEL    = 32'hBAD0_BAD1;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  stall_C;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instructions_out;
  logic        valid_out;

  fetch_unit #(
    .RESET_PC  (TB_RESET_PC),
    .BUF_DEPTH (TB_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_C          (stall_C),
    .redirect_en      (redirect_en),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .pc_out           (pc_out),
    .instructions_out (instructions_out),
    .valid_out        (valid_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state.
  logic [31:0] exp_q[$];
  logic [31:0] launch_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] mdl_fetch;
  bit          mdl_drop;
  bit          prev_req, prev_ack, prev_stall0;
  logic [31:0] prev_addr;
  int          mem_wait, mem_lat, lat_min, lat_max;
  int          cyc, first_valid;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic logic [31:0] launch_at(input int i);
    return (i < launch_log.size()) ? launch_log[i] : SENTINEL;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : SENTINEL;
  endfunction

  task automatic reset_model();
    exp_q.delete();
    launch_log.delete();
    pop_log.delete();
    mdl_fetch   = TB_RESET_PC;
    mdl_drop    = 1'b0;
    prev_req    = 1'b0;
    prev_ack    = 1'b0;
    prev_stall0 = 1'b0;
    prev_addr   = '0;
    mem_wait    = 0;
    mem_lat     = 1;
    cyc         = 0;
    first_valid = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req),  32'd0);
    check({tag, "_addr"},  imem_addr,      TB_RESET_PC);
    check({tag, "_valid"}, 32'(valid_out), 32'd0);
    check({tag, "_pc"},    pc_out,         EMPTY_WORD);
    check({tag, "_instr"}, instructions_out, EMPTY_WORD);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall_C = '0; redirect_en = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    reset_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: memory model reacts to the registered request, the
  // stimulus is applied, then the head and the request stream are checked.
  task automatic cycle(input logic [3:0] st, input logic rd, input logic [31:0] rpc);
    bit launch, kept, mdl_valid;
    @(negedge clk);
    cyc++;
    launch = imem_req && (!prev_req || prev_ack);
    if (prev_req && !prev_ack) begin
      check("req_hold",  32'(imem_req), 32'd1);
      check("addr_hold", imem_addr,     prev_addr);
    end
    if (launch) begin
      check("launch_addr",  imem_addr,         mdl_fetch);
      check("launch_stall", 32'(prev_stall0), 32'd0);
      launch_log.push_back(imem_addr);
      mem_wait = 0;
      mem_lat  = int'($urandom_range(lat_max, lat_min));
    end
    imem_ack    = imem_req && (mem_wait == mem_lat - 1);
    imem_rdata  = imem_ack ? instr_of(imem_addr) : 32'hDEAD_BEEF;
    stall_C     = st;
    redirect_en = rd;
    redirect_pc = rpc;
    #1;
    kept = imem_ack && !mdl_drop && !rd;
    if (BYP && kept) exp_q.push_back(imem_addr);
    mdl_valid = (exp_q.size() != 0);
    check("valid", 32'(valid_out), 32'(mdl_valid));
    if (mdl_valid) begin
      check("pc_out", pc_out, exp_q[0]);
      check("instr",  instructions_out, instr_of(exp_q[0]));
      if (first_valid < 0) first_valid = cyc;
    end else begin
      check("pc_empty",    pc_out,           EMPTY_WORD);
      check("instr_empty", instructions_out, EMPTY_WORD);
    end
    if (mdl_valid && !st[1] && !rd) begin
      pop_log.push_back(exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (!BYP && kept) exp_q.push_back(imem_addr);
    if (kept)     mdl_fetch = imem_addr + 32'd4;
    if (imem_ack) mdl_drop  = 1'b0;
    if (rd) begin
      exp_q.delete();
      mdl_fetch = rpc;
      if (imem_req && !imem_ack) mdl_drop = 1'b1;
    end
    check("depth_bound", 32'(exp_q.size() <= TB_DEPTH), 32'd1);
    if (imem_req) mem_wait++;
    prev_req    = imem_req;
    prev_ack    = imem_ack;
    prev_addr   = imem_addr;
    prev_stall0 = st[0];
  endtask

  initial begin
    int found;
    logic [31:0] rnd;
    logic [3:0]  st;
    rst = 1'b1; stall_C = '0; redirect_en = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    reset_model();
    lat_min = 1; lat_max = 1;

    // Reset then free-run with single-cycle ack.
    do_reset();
    repeat (12) cycle(4'b0000, 1'b0, '0);
    check("fr_launch0", launch_at(0), 32'h0);
    check("fr_launch1", launch_at(1), 32'h4);
    check("fr_launch2", launch_at(2), 32'h8);
    check("fr_pop0",    pop_at(0),    32'h0);
    check("fr_pop1",    pop_at(1),    32'h4);
    check("fr_pop2",    pop_at(2),    32'h8);
    check("fr_first_valid_cycle", 32'(first_valid), BYP ? 32'd1 : 32'd2);
    check("fr_throughput", 32'(pop_log.size()), BYP ? 32'd12 : 32'd11);

    // IF/ID stall fills the buffer and stops requests.
    do_reset();
    repeat (5) cycle(4'b0010, 1'b0, '0);
    check("stall_req_low",  32'(imem_req),  32'd0);
    check("stall_head_pc",  pc_out,         32'h0);
    check("stall_valid",    32'(valid_out), 32'd1);
    repeat (6) cycle(4'b0000, 1'b0, '0);
    check("stall_pop0", pop_at(0), 32'h0);
    check("stall_pop1", pop_at(1), 32'h4);
    check("stall_pop2", pop_at(2), 32'h8);
    check("stall_pop3", pop_at(3), 32'hC);

    // Redirect while a 3-cycle access is waiting.
    lat_min = 3; lat_max = 3;
    do_reset();
    cycle(4'b0000, 1'b0, '0);
    cycle(4'b0000, 1'b1, 32'h100);
    repeat (8) cycle(4'b0000, 1'b0, '0);
    check("rw_launch0", launch_at(0), 32'h0);
    check("rw_launch1", launch_at(1), 32'h100);
    check("rw_pop0",    pop_at(0),    32'h100);

    // Two redirects during one in-flight access: the later wins.
    lat_min = 4; lat_max = 4;
    do_reset();
    cycle(4'b0000, 1'b0, '0);
    cycle(4'b0000, 1'b1, 32'h200);
    cycle(4'b0000, 1'b1, 32'h300);
    repeat (12) cycle(4'b0000, 1'b0, '0);
    check("dr_launch1", launch_at(1), 32'h300);
    check("dr_pop0",    pop_at(0),    32'h300);
    found = 0;
    foreach (launch_log[i]) if (launch_log[i] == 32'h200) found++;
    foreach (pop_log[i])    if (pop_log[i]    == 32'h200) found++;
    check("dr_no_200", 32'(found), 32'd0);

    // Address wrap-around from the top of the address space.
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (4) cycle(4'b0000, 1'b0, '0);
    cycle(4'b0000, 1'b1, 32'hFFFF_FFF8);
    launch_log.delete();
    pop_log.delete();
    repeat (6) cycle(4'b0000, 1'b0, '0);
    check("wrap_launch0", launch_at(0), 32'hFFFF_FFF8);
    check("wrap_launch1", launch_at(1), 32'hFFFF_FFFC);
    check("wrap_launch2", launch_at(2), 32'h0000_0000);
    check("wrap_pop2",    pop_at(2),    32'h0000_0000);

    // Reset pulsed while a request is outstanding.
    lat_min = 3; lat_max = 3;
    do_reset();
    cycle(4'b0000, 1'b0, '0);
    check("mid_req_before", 32'(imem_req), 32'd1);
    rst = 1'b1;
    imem_ack = 1'b0;
    #1;
    check_reset_outputs("mid_async");
    @(negedge clk);
    check_reset_outputs("mid_next");
    reset_model();
    rst = 1'b0;
    repeat (8) cycle(4'b0000, 1'b0, '0);
    check("mid_relaunch", launch_at(0), TB_RESET_PC);
    check("mid_pop0",     pop_at(0),    TB_RESET_PC);

    // Randomized traffic: stalls, redirects and variable memory latency.
    lat_min = 1; lat_max = 3;
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      st[0]   = ($urandom_range(3, 0) == 0);
      st[1]   = ($urandom_range(2, 0) == 0);
      st[3:2] = 2'($urandom_range(3, 0));
      rnd     = $urandom;
      if ($urandom_range(7, 0) == 0) rnd = 32'hFFFF_FFF0 | (rnd & 32'h0000_000F);
      cycle(st, ($urandom_range(19, 0) == 0), rnd & 32'hFFFF_FFFC);
    end
    check("rand_activity", 32'(pop_log.size() > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the fetch PC and issues one outstanding request at a time to instruction memory over a req/ack handshake. Queues returned {pc, instruction} pairs in a small buffer and presents the head to IF/ID. Handles branch/jump redirects, including redirects that arrive while a memory access is in flight.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset.
- BUF_DEPTH, 2, fetch buffer entries; legal values are 2 and 4.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall_C  in  4  hazard-unit stall vector. Bit 0 freezes new fetch launches; bit 1 means IF/ID is holding, so no pop.
- redirect_en  in  1  taken branch/jump; flush and restart.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  memory request, registered.
- imem_addr  out  32  request address, registered, word aligned.
- imem_ack  in  1  request complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- pc_out  out  32  head PC; `INIT_32` when empty.
- instructions_out  out  32  head instruction; `INIT_32` (NOP) when empty.
- valid_out  out  1  head entry valid.

## Operation
- States: IDLE (no request), REQ (request outstanding), DROP (outstanding request whose data is discarded).
- **Launch condition L:** !stall_C[0] && next_count < BUF_DEPTH && no redirect pending.
- **Push, pop, next_count:**
  - push = ack in REQ without redirect.
  - pop = valid_out && !stall_C[1].
  - next_count = count + push − pop.
- **IDLE:**
  - If L: imem_req←1, imem_addr←fetch_pc, go to REQ.
- **REQ:**
  - imem_req and imem_addr hold stable until ack.
  - On ack: push {imem_addr, imem_rdata} and set fetch_pc ← imem_addr+4.
  - After an ack, if L holds, relaunch back-to-back at the new fetch_pc; otherwise go to IDLE.
- **Redirect:**
  - Buffer is cleared and fetch_pc ← redirect_pc, in every state.
  - Redirect has priority over push and pop.
  - In REQ with ack in the same cycle: data is discarded, and the fetch relaunches at redirect_pc if !stall_C[0].
  - In REQ without ack: go to DROP; imem_req and imem_addr stay unchanged.
- **DROP:**
  - Further redirects overwrite fetch_pc; the latest one wins.
  - On ack: discard data, then launch at fetch_pc if L holds, otherwise go to IDLE.
- **Arithmetic:** fetch_pc increments by 4 modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- **Bounds:** count never exceeds BUF_DEPTH. A launch only happens when space is guaranteed for its data.

## Timing
- **Reset values:**
  - imem_req=0, imem_addr=RESET_PC, state IDLE, fetch_pc=RESET_PC, count=0.
  - pc_out=`INIT_32`, instructions_out=`INIT_32`, valid_out=0.
- **Reset mid-access:** rst asserted mid-access abandons the request. Memory must tolerate the dropped request.
- **First request:** imem_req rises on the first clk edge after rst deasserts.
- **Latency:** ack at edge N puts the entry at the buffer head (visible on outputs) after edge N, if the buffer was empty.
- **Throughput:** with single-cycle ack and no stalls, one instruction per cycle.
- **Redirect:** visible in the first cycle after redirect_en. valid_out=0 and imem_addr=redirect_pc on the next request.
- **Simultaneous push and pop:** count unchanged.

## Configuration
- **FETCH_BYPASS_EN defined:**
  - When the buffer is empty and an ack arrives in REQ without redirect, imem_rdata and imem_addr drive the outputs combinationally with valid_out=1.
  - If pop occurs that cycle, the entry is not written to the buffer.
  - First-instruction latency drops by one cycle.
- **Not defined:** outputs come from buffer registers only. There is no combinational path from imem_* to the outputs.

## Structure
- **Shared definitions header:**
  - `INIT_32`.
  - State encodings FETCH_IDLE, FETCH_REQ, FETCH_DROP.
  - Default reset PC constant.
- **Sub-module:** fetch_buf, a BUF_DEPTH-entry FIFO of 64-bit {pc, instr}. Ports: push, pop, clear, count, head.

## Test plan
- **Reset then free-run:** reset, then single-cycle ack with rdata=addr^32'hA5A5_A5A5, no stalls → imem_addr 0,4,8,… back-to-back. pc_out sequence 0,4,8 with matching instructions.
- **IF/ID stall:** stall_C[1]=1 for 5 cycles → buffer fills to BUF_DEPTH, imem_req drops, head holds pc 0. On release, pops resume with no lost or duplicated PC.
- **Redirect while waiting:**
  - Ack latency 3 cycles; redirect_pc=32'h100 in the cycle after req.
  - → imem_addr is held until ack, and that data is discarded.
  - → Next request is at 32'h100; first valid pc_out is 32'h100.
- **Double redirect in DROP:** targets 32'h200 then 32'h300 → only 32'h300 is fetched; no entry from 32'h200 appears.
- **Wrap-around:** RESET_PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Reset mid-access, plus bypass:** rst pulsed while imem_req=1 → all outputs at reset values next cycle. With FETCH_BYPASS_EN, the first instruction is valid in the same cycle as its ack.
